// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus wrapper: arbiter state encoding,
// master identifiers and widths used by the bus muxes and address decoder.
package bus_pkg;

    // Arbiter state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OWN_M1 = 2'd1;
    localparam logic [1:0] ST_OWN_M2 = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    typedef enum logic [1:0] {
        STATE_IDLE   = ST_IDLE,
        STATE_OWN_M1 = ST_OWN_M1,
        STATE_OWN_M2 = ST_OWN_M2,
        STATE_GAP    = ST_GAP
    } arb_state_e;

    // Master identifiers; also the msel encoding seen by the bus muxes
    localparam logic MID_M1 = 1'b0;
    localparam logic MID_M2 = 1'b1;

    // Widths shared with the bus wrapper
    localparam int unsigned NUM_MASTERS = 2;
    localparam int unsigned MID_W       = 1;
    localparam int unsigned GAP_CNT_W   = 4;
    localparam int unsigned BUS_ADDR_W  = 16;
    localparam int unsigned BUS_DATA_W  = 8;

    // The master that is not `mid`
    function automatic logic other_mid(input logic mid);
        return ~mid;
    endfunction

endpackage

// File: rtl/bus_arbiter_split.sv
// Two-master split-capable bus arbiter for the serial system bus.
// Shares the bus between master_port (m1) and bus_bridge_master (m2), parks a
// split master and re-grants it with priority once the split slave resumes.
// All outputs are registered.
// Optional build macro ARB_ROUND_ROBIN_EN: ties go to the master that did not
// own the bus most recently (PRIO_M2 is then ignored).
module bus_arbiter_split
    import bus_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1,
    parameter bit          PRIO_M2    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic m1_breq,
    input  logic m2_breq,
    output logic m1_bgrant,
    output logic m2_bgrant,
    output logic msel,
    output logic m1_split,
    output logic m2_split,
    input  logic s_split,
    input  logic s_resume,
    output logic split_grant
);

    // Last counter value spent in GAP before returning to IDLE
    localparam logic [GAP_CNT_W-1:0] GAP_LAST =
        (GAP_CYCLES == 0) ? '0 : GAP_CNT_W'(GAP_CYCLES - 1);

    // Where an owner goes on release or split; GAP is skipped entirely at 0
    localparam arb_state_e REL_STATE = (GAP_CYCLES == 0) ? STATE_IDLE : STATE_GAP;

    arb_state_e             state_q, state_d;
    logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic                   m1_bgrant_d, m2_bgrant_d, msel_d;
    logic                   m1_split_d, m2_split_d, split_grant_d;

    logic                   split_pend;
    logic                   split_mid;
    logic                   split_breq;
    logic                   resume_ok;
    logic                   req_m1, req_m2;
    logic                   pick_m2;

`ifdef ARB_ROUND_ROBIN_EN
    logic                   last_mid_q, last_mid_d;
`endif

    // Split tracking: the mX_split flags themselves record the parked owner
    always_comb begin
        split_pend = m1_split | m2_split;
        split_mid  = m2_split ? MID_M2 : MID_M1;
        split_breq = m2_split ? m2_breq : m1_breq;
        // A parked master that has dropped its request can no longer be resumed
        resume_ok  = split_pend & s_resume & split_breq;
        // A parked master never competes as a fresh request
        req_m1     = m1_breq & ~m1_split;
        req_m2     = m2_breq & ~m2_split;
    end

    // Tie-break between simultaneous fresh requests
`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        pick_m2 = (other_mid(last_mid_q) == MID_M2);
    end
`else
    always_comb begin
        pick_m2 = PRIO_M2;
    end
`endif

    // Next-state, gap counter, split bookkeeping and registered-output inputs
    always_comb begin
        state_d       = state_q;
        gap_cnt_d     = gap_cnt_q;
        m1_split_d    = m1_split;
        m2_split_d    = m2_split;
        split_grant_d = 1'b0;

        // Cancellation applies in every state
        if (m1_split && !m1_breq) begin
            m1_split_d = 1'b0;
        end
        if (m2_split && !m2_breq) begin
            m2_split_d = 1'b0;
        end

        unique case (state_q)
            STATE_IDLE: begin
                if (resume_ok) begin
                    // Resuming a split outranks any new request
                    state_d       = (split_mid == MID_M2) ? STATE_OWN_M2 : STATE_OWN_M1;
                    split_grant_d = 1'b1;
                    m1_split_d    = 1'b0;
                    m2_split_d    = 1'b0;
                end else if (req_m1 && req_m2) begin
                    state_d = pick_m2 ? STATE_OWN_M2 : STATE_OWN_M1;
                end else if (req_m1) begin
                    state_d = STATE_OWN_M1;
                end else if (req_m2) begin
                    state_d = STATE_OWN_M2;
                end
            end

            STATE_OWN_M1: begin
                // A release in the same cycle as s_split wins: no split recorded
                if (!m1_breq) begin
                    state_d   = REL_STATE;
                    gap_cnt_d = '0;
                end else if (s_split && !split_pend) begin
                    m1_split_d = 1'b1;
                    state_d    = REL_STATE;
                    gap_cnt_d  = '0;
                end
            end

            STATE_OWN_M2: begin
                if (!m2_breq) begin
                    state_d   = REL_STATE;
                    gap_cnt_d = '0;
                end else if (s_split && !split_pend) begin
                    m2_split_d = 1'b1;
                    state_d    = REL_STATE;
                    gap_cnt_d  = '0;
                end
            end

            STATE_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = STATE_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d   = STATE_IDLE;
                gap_cnt_d = '0;
            end
        endcase

        // Grants follow the ownership state; msel moves only with a grant
        m1_bgrant_d = (state_d == STATE_OWN_M1);
        m2_bgrant_d = (state_d == STATE_OWN_M2);
        if (state_d == STATE_OWN_M2) begin
            msel_d = MID_M2;
        end else if (state_d == STATE_OWN_M1) begin
            msel_d = MID_M1;
        end else begin
            msel_d = msel;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Most recent owner, updated on every grant including split resumes
    always_comb begin
        last_mid_d = last_mid_q;
        if (state_d == STATE_OWN_M1) begin
            last_mid_d = MID_M1;
        end else if (state_d == STATE_OWN_M2) begin
            last_mid_d = MID_M2;
        end
    end

    // Last-owner register; resets to m2 so m1 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_mid_q <= MID_M2;
        end else begin
            last_mid_q <= last_mid_d;
        end
    end
`endif

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= STATE_IDLE;
            gap_cnt_q   <= '0;
            m1_bgrant   <= 1'b0;
            m2_bgrant   <= 1'b0;
            msel        <= MID_M1;
            m1_split    <= 1'b0;
            m2_split    <= 1'b0;
            split_grant <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            m1_bgrant   <= m1_bgrant_d;
            m2_bgrant   <= m2_bgrant_d;
            msel        <= msel_d;
            m1_split    <= m1_split_d;
            m2_split    <= m2_split_d;
            split_grant <= split_grant_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_split.sv
// Self-checking bench for bus_arbiter_split. Two instances (GAP_CYCLES=1/PRIO_M2=0
// and GAP_CYCLES=0/PRIO_M2=1) share one stimulus stream; each is checked every
// cycle against a behavioural model, plus directed literal checks on instance 0.
// Honours ARB_ROUND_ROBIN_EN the same way as the design.
module tb_bus_arbiter_split;

    logic clk = 1'b0;
    logic rst;
    logic m1_breq, m2_breq, s_split, s_resume;

    logic a_g1, a_g2, a_msel, a_s1, a_s2, a_sg;
    logic b_g1, b_g2, b_msel, b_s1, b_s2, b_sg;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter_split #(.GAP_CYCLES(1), .PRIO_M2(1'b0)) dut_a (
        .clk(clk), .rst(rst), .m1_breq(m1_breq), .m2_breq(m2_breq),
        .m1_bgrant(a_g1), .m2_bgrant(a_g2), .msel(a_msel),
        .m1_split(a_s1), .m2_split(a_s2),
        .s_split(s_split), .s_resume(s_resume), .split_grant(a_sg)
    );

    bus_arbiter_split #(.GAP_CYCLES(0), .PRIO_M2(1'b1)) dut_b (
        .clk(clk), .rst(rst), .m1_breq(m1_breq), .m2_breq(m2_breq),
        .m1_bgrant(b_g1), .m2_bgrant(b_g2), .msel(b_msel),
        .m1_split(b_s1), .m2_split(b_s2),
        .s_split(s_split), .s_resume(s_resume), .split_grant(b_sg)
    );

    // Behavioural model: owner (0 none, 1, 2), cooldown cycles left before
    // arbitration, parked master (0 none), last owner, msel and resume pulse.
    typedef struct {
        int owner;
        int cool;
        int parked;
        int last;
        bit msel;
        bit pulse;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.owner = 0; r.cool = 0; r.parked = 0; r.last = 2; r.msel = 0; r.pulse = 0;
        return r;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t s, input int gap, input bit prio2,
                                      input bit b1, input bit b2, input bit ss, input bit sr);
        mdl_t n;
        bit [2:1] req;
        bit c1, c2;
        int win;
        n = s;
        n.pulse = 0;
        req = {b2, b1};
        if (s.parked != 0 && !req[s.parked]) n.parked = 0;
        if (s.owner != 0) begin
            if (!req[s.owner]) begin
                n.owner = 0; n.cool = gap;
            end else if (ss && s.parked == 0) begin
                n.parked = s.owner; n.owner = 0; n.cool = gap;
            end
        end else if (s.cool > 0) begin
            n.cool = s.cool - 1;
        end else if (n.parked != 0 && sr) begin
            n.owner = n.parked; n.parked = 0; n.pulse = 1;
        end else begin
            c1 = b1 && (n.parked != 1);
            c2 = b2 && (n.parked != 2);
            win = 0;
            if (c1 && c2) begin
`ifdef ARB_ROUND_ROBIN_EN
                win = (s.last == 1) ? 2 : 1;
`else
                win = prio2 ? 2 : 1;
`endif
            end else if (c1) begin
                win = 1;
            end else if (c2) begin
                win = 2;
            end
            n.owner = win;
        end
        if (n.owner != 0) begin
            n.last = n.owner;
            n.msel = (n.owner == 2);
        end
        return n;
    endfunction

    function automatic logic [5:0] mdl_out(input mdl_t s);
        return {s.owner == 1, s.owner == 2, s.msel, s.parked == 1, s.parked == 2, s.pulse};
    endfunction

    // Model advances on the same edges as the DUTs
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= mdl_reset();
            mb <= mdl_reset();
        end else begin
            ma <= mdl_step(ma, 1, 1'b0, m1_breq, m2_breq, s_split, s_resume);
            mb <= mdl_step(mb, 0, 1'b1, m1_breq, m2_breq, s_split, s_resume);
        end
    end

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b (g1 g2 msel s1 s2 sg)",
                     name, $time, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_a", {a_g1, a_g2, a_msel, a_s1, a_s2, a_sg}, mdl_out(ma));
            check("model_b", {b_g1, b_g2, b_msel, b_s1, b_s2, b_sg}, mdl_out(mb));
            check1("excl_a", a_g1 & a_g2, 1'b0);
            check1("excl_b", b_g1 & b_g2, 1'b0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        m1_breq = 0; m2_breq = 0; s_split = 0; s_resume = 0;
        repeat (n) step();
    endtask

`ifdef ARB_ROUND_ROBIN_EN
    int seq[$];
    int h1, h2;
    bit p1, p2;
`endif

    initial begin
        rst = 1'b1;
        m1_breq = 0; m2_breq = 0; s_split = 0; s_resume = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {a_g1, a_g2, a_msel, a_s1, a_s2, a_sg}, 6'b000000);
        rst = 1'b0;
        chk_en = 1'b1;
        step();

        // Simultaneous request, m1 wins; m2 granted 3 cycles after m1 release
        m1_breq = 1; m2_breq = 1;                          // cycle 0
        step();                                             // cycle 1
        check("sim_grant_m1", {a_g1, a_g2, a_msel}, {3'b100});
        repeat (4) step();                                  // cycle 5
        m1_breq = 0;
        step();                                             // cycle 6
        check("sim_drop", {a_g1, a_g2}, 6'b00);
        step();                                             // cycle 7
        check("sim_gap", {a_g1, a_g2}, 6'b00);
        step();                                             // cycle 8
        check("sim_grant_m2", {a_g1, a_g2, a_msel}, {3'b011});
        idle(4);

        // Split and resume
        m1_breq = 1;                                        // cycle 0
        step();                                             // cycle 1
        check1("split_own", a_g1, 1'b1);
        step(); step();                                     // cycle 3
        s_split = 1;
        step();                                             // cycle 4
        s_split = 0;
        check("split_park", {a_g1, a_s1}, 6'b01);
        m2_breq = 1;
        repeat (3) step();                                  // cycle 7
        check("split_m2_own", {a_g1, a_g2, a_msel, a_s1}, {4'b0111});
        s_resume = 1;
        repeat (3) step();                                  // cycle 10
        m2_breq = 0;
        step();                                             // cycle 11
        check("split_m2_rel", {a_g2, a_s1, a_sg}, 6'b010);
        step();                                             // cycle 12
        m2_breq = 1;
        step();                                             // cycle 13
        check("split_resume", {a_g1, a_g2, a_msel, a_s1, a_s2, a_sg}, 6'b100001);
        step();                                             // cycle 14
        check("split_pulse_end", {a_g1, a_g2, a_sg}, 6'b100);
        idle(4);

        // Split cancel: parked m2 drops its request
        m2_breq = 1;
        step();
        check1("cancel_own", a_g2, 1'b1);
        s_split = 1;
        step();
        s_split = 0;
        check("cancel_park", {a_g2, a_s2}, 6'b01);
        m2_breq = 0;
        step();
        check1("cancel_clear", a_s2, 1'b0);
        s_resume = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("cancel_no_resume", {a_g1, a_g2, a_sg}, 6'b000);
        end
        idle(4);

        // Release and split in the same cycle
        m1_breq = 1;
        step();
        check1("coll_own", a_g1, 1'b1);
        m1_breq = 0; s_split = 1;
        step();
        s_split = 0;
        check("coll_rel", {a_g1, a_s1}, 6'b00);
        step();
        check("coll_gap", {a_g1, a_s1}, 6'b00);
        idle(4);

        // Asynchronous reset in the middle of an ownership
        m1_breq = 1;
        step(); step();
        check1("rst_pre_own", a_g1, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_async", {a_g1, a_g2, a_msel, a_s1, a_s2, a_sg}, 6'b000000);
        @(posedge clk);
        #2 rst = 1'b0;
        step();
        check1("rst_regrant", a_g1, 1'b1);
        idle(4);

`ifdef ARB_ROUND_ROBIN_EN
        // Both masters request continuously and hold two cycles each
        h1 = 0; h2 = 0; p1 = 0; p2 = 0;
        m1_breq = 1; m2_breq = 1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (a_g1 && !p1) seq.push_back(1);
            if (a_g2 && !p2) seq.push_back(2);
            p1 = a_g1; p2 = a_g2;
            m1_breq = 1; m2_breq = 1;
            if (a_g1) begin
                h1++;
                if (h1 == 2) begin m1_breq = 0; h1 = 0; end
            end
            if (a_g2) begin
                h2++;
                if (h2 == 2) begin m2_breq = 0; h2 = 0; end
            end
        end
        check1("rr_enough_grants", seq.size() >= 6, 1'b1);
        if (seq.size() > 0) check1("rr_first_m1", seq[0] == 1, 1'b1);
        for (int i = 1; i < seq.size(); i++) begin
            check1("rr_alternate", seq[i] == ((seq[i-1] == 1) ? 2 : 1), 1'b1);
        end
        idle(4);
`endif

        // Randomized traffic with held requests, split pulses and resume levels
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(9) == 0) m1_breq = ~m1_breq;
            if ($urandom_range(9) == 0) m2_breq = ~m2_breq;
            s_split = ($urandom_range(5) == 0);
            if ($urandom_range(7) == 0) s_resume = ~s_resume;
            step();
        end
        idle(3);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_split.md
Name: bus_arbiter_split

Overview:
- Two-master, split-capable bus arbiter for the serial system bus. Shares the bus between master_port and bus_bridge_master.
- Grants ownership from bus requests, drives the master-select used by the bus muxes, parks a split master, and re-grants it with priority when the split slave is ready to resume.
- Registered outputs throughout; sits inside the bus wrapper next to the address decoder.

Parameters:
- GAP_CYCLES, 1, idle cycles between a release and the next grant (0..15; 0 = direct handover via IDLE).
- PRIO_M2, 0, fixed-priority winner on simultaneous requests (0 = master 1 wins, 1 = master 2 wins).

Ports:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- m1_breq  in  1  master 1 bus request (held for the whole transaction)
- m2_breq  in  1  master 2 bus request
- m1_bgrant  out  1  master 1 grant
- m2_bgrant  out  1  master 2 grant
- msel  out  1  bus mux select (0 = m1, 1 = m2)
- m1_split  out  1  master 1 is parked on a split
- m2_split  out  1  master 2 is parked on a split
- s_split  in  1  addressed slave splits the current transaction (1-cycle pulse)
- s_resume  in  1  split slave is ready to continue (level)
- split_grant  out  1  1-cycle pulse telling the slave its split master is re-granted

Behaviour:
- Reset (async, immediate):
  - m1_bgrant=0, m2_bgrant=0, msel=0, m1_split=0, m2_split=0, split_grant=0.
  - State=IDLE, gap counter=0, split owner cleared.
- Latency: breq sampled high in cycle N in IDLE gives bgrant high in cycle N+1. Decisions are registered; there is no combinational path from input to output.
- States: IDLE, OWN_M1, OWN_M2, GAP.
- IDLE:
  - Split pending and s_resume=1: grant the split owner, pulse split_grant for one cycle, clear its mX_split. This has priority over all new requests.
  - Otherwise arbitrate among requesting masters, excluding any master currently split. Tie-break by PRIO_M2.
  - msel updates in the same cycle as bgrant. With no grant, msel holds its last value.
- OWN_Mx:
  - Grant is held while mx_breq=1.
  - mx_breq=0: bgrant drops next cycle; go to GAP, or to IDLE if GAP_CYCLES=0.
  - s_split=1: bgrant drops next cycle, mx_split=1, record owner; go to GAP/IDLE. The master keeps breq high while parked.
  - breq drop and s_split in the same cycle: treated as a plain release with no split recorded.
- GAP: counts GAP_CYCLES cycles with both grants 0, then goes to IDLE.
- At most one split outstanding.
  - s_split outside the OWN states is ignored.
  - The non-split master may own the bus while a split is pending.
  - s_resume during that ownership waits until release.
- Parked master drops breq: split is cancelled, mx_split clears next cycle, s_resume is then ignored.
- Invariant: m1_bgrant & m2_bgrant is never 1.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: ties resolve to the master that did not own the bus most recently. A last-owner register resets to m2, so m1 wins the first tie. PRIO_M2 is ignored.
- Undefined: fixed priority per PRIO_M2.

Decomposition:
- Shared package bus_pkg holds:
  - State encoding localparams: ST_IDLE, ST_OWN_M1, ST_OWN_M2, ST_GAP.
  - Master-id constants: MID_M1=0, MID_M2=1.
  - Widths shared with the bus wrapper.
- No sub-module. The gap counter and split tracker stay inline; the whole block is one FSM of about 150–250 lines.

Test Plan:
- Reset mid-ownership: m1 granted, assert rst in the middle of a cycle → all outputs 0 immediately. Release rst, m1_breq still high → m1_bgrant=1 one cycle after the first rising edge.
- Simultaneous request: m1_breq=m2_breq=1 at cycle 0, PRIO_M2=0 → m1_bgrant=1, msel=0 at cycle 1. m1 releases at cycle 5 → m2_bgrant=1, msel=1 at cycle 8 (1 cycle drop + GAP_CYCLES=1 + grant).
- Split and resume:
  - m1 owns, s_split pulse at cycle 3 → m1_bgrant=0 and m1_split=1 at cycle 4.
  - m2 is granted next and owns until cycle 10; s_resume=1 from cycle 7.
  - After m2 releases → m1_bgrant=1, split_grant pulse, m1_split=0 in the same cycle, before any new m2 request.
- Split cancel: m2 split, then m2_breq drops → m2_split=0 next cycle; later s_resume=1 produces no grant and no split_grant.
- Release/split collision: owner drops breq in the same cycle as s_split=1 → no mx_split assertion, normal GAP→IDLE.
- ARB_ROUND_ROBIN_EN: both masters request continuously, each holding for 2 cycles → grants alternate m1, m2, m1, m2; both grants are never high together.
